reg_op_sequencer: RTL

REG_OP_SEQUENCER -- requirements
Module: reg_op_sequencer

---
 rtl/reg_op_sequencer.sv | 219 +++++++++++++++++++++
 1 files changed

// File: rtl/reg_op_sequencer.sv
// ---------------------------------------------------------------------------
// reg_op_sequencer
//
// Runs one register-to-register command through four states:
// IDLE -> READ -> EXEC -> WRITE -> IDLE. Each non-IDLE state lasts one cycle.
// The command fields are captured on the accept edge. Source operands come
// from an external register file. The result is written back through a
// one-cycle replace strobe.
//
// Ports
//   clk, rst                  clock and synchronous active-high reset
//   cmdValid / cmdReady       command handshake (ready only in IDLE, not in rst)
//   cmdOp[2:0]                opcode: ADD SUB AND OR XOR MOV LOADI NOP
//   cmdDst/cmdSrcA/cmdSrcB    register indices (4 bits each)
//   cmdImm[7:0]               immediate operand for LOADI
//   A_sel/B_sel, A/B          register file read selects and read data
//   replaceSel/Data/En        register file write port
//   done                      one-cycle completion pulse, coincident with WRITE
//   busy                      high in any state other than IDLE
//
// Optional feature: define REG_OP_SEQUENCER_FLAGS_EN to add zeroFlag and
// carryFlag. Both flags update when ops ADD..XOR complete.
// ---------------------------------------------------------------------------
module reg_op_sequencer (
   input  logic       clk,
   input  logic       rst,
   input  logic       cmdValid,
   output logic       cmdReady,
   input  logic [2:0] cmdOp,
   input  logic [3:0] cmdDst,
   input  logic [3:0] cmdSrcA,
   input  logic [3:0] cmdSrcB,
   input  logic [7:0] cmdImm,
   output logic [3:0] A_sel,
   output logic [3:0] B_sel,
   input  logic [7:0] A,
   input  logic [7:0] B,
   output logic [3:0] replaceSel,
   output logic [7:0] replaceData,
   output logic       replaceEn,
   output logic       done,
   output logic       busy
`ifdef REG_OP_SEQUENCER_FLAGS_EN
   ,
   output logic       zeroFlag,
   output logic       carryFlag
`endif
);

   typedef enum logic [1:0] {IDLE, READ, EXEC, WRITE} state_t;

   localparam logic [2:0] OP_ADD = 3'd0, OP_SUB = 3'd1, OP_AND = 3'd2, OP_OR = 3'd3,
                          OP_XOR = 3'd4, OP_MOV = 3'd5, OP_LOADI = 3'd6, OP_NOP = 3'd7;

   state_t     state_q, state_d;
   logic [2:0] op_q, op_d;
   logic [3:0] dst_q, dst_d;
   logic [7:0] imm_q, imm_d;
   logic [3:0] a_sel_q, a_sel_d;
   logic [3:0] b_sel_q, b_sel_d;
   logic [7:0] a_q, a_d;
   logic [7:0] b_q, b_d;
   logic [3:0] rsel_q, rsel_d;
   logic [7:0] rdata_q, rdata_d;
   logic       ren_q, ren_d;
   logic       done_q, done_d;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
   logic       carry_q, carry_d;
   logic       zf_q, zf_d;
   logic       cf_q, cf_d;
`endif

   // 8-bit wrapping ALU. NOP yields zero, but no write is issued for it.
   function automatic logic [7:0] alu_result(input logic [2:0] op, input logic [7:0] a,
                                             input logic [7:0] b, input logic [7:0] imm);
      case (op)
         OP_ADD:   return a + b;
         OP_SUB:   return a - b;
         OP_AND:   return a & b;
         OP_OR:    return a | b;
         OP_XOR:   return a ^ b;
         OP_MOV:   return a;
         OP_LOADI: return imm;
         default:  return 8'h00;
      endcase
   endfunction

`ifdef REG_OP_SEQUENCER_FLAGS_EN
   // ADD carry: the wrapped sum is smaller than an addend. SUB borrow: a < b.
   function automatic logic alu_carry(input logic [2:0] op, input logic [7:0] a,
                                      input logic [7:0] b);
      logic [7:0] s;
      s = a + b;
      case (op)
         OP_ADD:  return (s < a);
         OP_SUB:  return (a < b);
         default: return 1'b0;
      endcase
   endfunction
`endif

   always_comb begin
      state_d = state_q;
      op_d    = op_q;
      dst_d   = dst_q;
      imm_d   = imm_q;
      a_sel_d = a_sel_q;
      b_sel_d = b_sel_q;
      a_d     = a_q;
      b_d     = b_q;
      rsel_d  = rsel_q;
      rdata_d = rdata_q;
      ren_d   = 1'b0;
      done_d  = 1'b0;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
      carry_d = carry_q;
      zf_d    = zf_q;
      cf_d    = cf_q;
`endif
      case (state_q)
         // Accept edge: capture the command and drive the read selects.
         IDLE: begin
            if (cmdValid) begin
               state_d = READ;
               op_d    = cmdOp;
               dst_d   = cmdDst;
               imm_d   = cmdImm;
               a_sel_d = cmdSrcA;
               b_sel_d = cmdSrcB;
            end
         end
         // Register file data is valid for the selects; sample it.
         READ: begin
            a_d     = A;
            b_d     = B;
            state_d = EXEC;
         end
         // Compute and present the write. NOP keeps the old sel/data.
         EXEC: begin
            state_d = WRITE;
            done_d  = 1'b1;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
            carry_d = alu_carry(op_q, a_q, b_q);
`endif
            if (op_q != OP_NOP) begin
               ren_d   = 1'b1;
               rsel_d  = dst_q;
               rdata_d = alu_result(op_q, a_q, b_q, imm_q);
            end
         end
         // Write lands at the edge that ends this cycle; flags commit here too.
         WRITE: begin
            state_d = IDLE;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
            if (op_q <= OP_XOR) begin
               zf_d = (rdata_q == 8'h00);
               cf_d = carry_q;
            end
`endif
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         op_q    <= OP_NOP;
         dst_q   <= 4'd0;
         imm_q   <= 8'h00;
         a_sel_q <= 4'd0;
         b_sel_q <= 4'd0;
         a_q     <= 8'h00;
         b_q     <= 8'h00;
         rsel_q  <= 4'd0;
         rdata_q <= 8'h00;
         ren_q   <= 1'b0;
         done_q  <= 1'b0;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
         carry_q <= 1'b0;
         zf_q    <= 1'b0;
         cf_q    <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         op_q    <= op_d;
         dst_q   <= dst_d;
         imm_q   <= imm_d;
         a_sel_q <= a_sel_d;
         b_sel_q <= b_sel_d;
         a_q     <= a_d;
         b_q     <= b_d;
         rsel_q  <= rsel_d;
         rdata_q <= rdata_d;
         ren_q   <= ren_d;
         done_q  <= done_d;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
         carry_q <= carry_d;
         zf_q    <= zf_d;
         cf_q    <= cf_d;
`endif
      end
   end

   // rst gates the strobe combinationally, so an aborted WRITE never lands.
   assign cmdReady    = (state_q == IDLE) && !rst;
   assign busy        = (state_q != IDLE);
   assign replaceEn   = ren_q && !rst;
   assign done        = done_q;
   assign A_sel       = a_sel_q;
   assign B_sel       = b_sel_q;
   assign replaceSel  = rsel_q;
   assign replaceData = rdata_q;
`ifdef REG_OP_SEQUENCER_FLAGS_EN
   assign zeroFlag    = zf_q;
   assign carryFlag   = cf_q;
`endif

endmodule
